// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with memory wait timeout and perf counters
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread_EX,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             br_taken_EX,
  input  logic             j_EX,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             redirect,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           mem_stall, freeze, loaduse, redir;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign freeze    = mem_stall | (state == S_HALT);
  assign loaduse   = memread_EX & (rd_EX != 5'd0) &
                     ((use_rs1_ID & (rs1_ID == rd_EX)) | (use_rs2_ID & (rs2_ID == rd_EX)));
  // A frozen EX branch keeps its redirect pending until the first unfrozen cycle.
  assign redir     = (br_taken_EX | j_EX) & ~freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      halted   <= (state_nxt == S_HALT);
      if (state == S_WAIT && state_nxt == S_HALT)
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    redirect     = 1'b0;

    case (state)
      S_RUN: begin
        if (mem_stall) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      S_WAIT: begin
        // Ready wins over the timeout when both land on the same cycle.
        if (dmem_ready) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCW'(MAX_WAIT)) begin
          state_nxt = S_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (!reset) begin
      if (freeze) begin
        stall_PC     = 1'b1;
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        stall_EX_MEM = 1'b1;
        stall_MEM_WB = 1'b1;
      end else if (redir) begin
        redirect    = 1'b1;
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (loaduse) begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end
    end
  end

  // Saturating counters; outputs are forced low during reset so nothing counts then.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_PC && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          memread_EX;
  logic [4:0]    rd_EX, rs1_ID, rs2_ID;
  logic          use_rs1_ID, use_rs2_ID, br_taken_EX, j_EX, dmem_req, dmem_ready;
  logic          stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, redirect, halted, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: consecutive wait cycles seen so far (0 = not waiting), halt flag, counts.
  int m_wait = 0;
  bit m_halt = 0;
  int m_scnt = 0;
  int m_fcnt = 0;
  bit e_stall_pc, e_redir;

  hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .memread_EX(memread_EX), .rd_EX(rd_EX),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .br_taken_EX(br_taken_EX), .j_EX(j_EX), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .redirect(redirect), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    memread_EX = 0; rd_EX = 0; rs1_ID = 0; rs2_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0;
    br_taken_EX = 0; j_EX = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // One cycle: check everything at the falling edge, then advance the model past the rising edge.
  task automatic tick(input string tag);
    bit frz, lu, rdr;
    logic [8:0] exp_v, got_v;
    @(negedge clk);
    frz = (dmem_req && !dmem_ready) || m_halt;
    lu  = memread_EX && rd_EX != 0 &&
          ((use_rs1_ID && rs1_ID == rd_EX) || (use_rs2_ID && rs2_ID == rd_EX));
    rdr = (br_taken_EX || j_EX) && !frz;
    // Order: stall PC,IF_ID,ID_EX,EX_MEM,MEM_WB / flush IF_ID,ID_EX,EX_MEM / redirect
    exp_v = 9'b0;
    if (!reset) begin
      if (frz)      exp_v = 9'b11111_000_0;
      else if (rdr) exp_v = 9'b00000_110_1;
      else if (lu)  exp_v = 9'b11000_010_0;
    end
    got_v = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
             flush_IF_ID, flush_ID_EX, flush_EX_MEM, redirect};
    check({tag, "_ctl"}, 32'(got_v), 32'(exp_v));
    check({tag, "_halted"}, 32'(halted), 32'(m_halt));
    check({tag, "_timeout"}, 32'(mem_timeout), 32'(m_halt));
    check({tag, "_scnt"}, 32'(stall_cnt), m_scnt);
    check({tag, "_fcnt"}, 32'(flush_cnt), m_fcnt);
    e_stall_pc = exp_v[8];
    e_redir    = exp_v[0];
    @(posedge clk);
    #1;
    if (reset) begin
      m_wait = 0; m_halt = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_stall_pc && m_scnt < CMAX) m_scnt++;
      if (e_redir && m_fcnt < CMAX) m_fcnt++;
      if (!m_halt) begin
        if (m_wait == 0) begin
          if (dmem_req && !dmem_ready) m_wait = 1;
        end else if (dmem_ready) m_wait = 0;
        else if (m_wait == MAXW) m_halt = 1;
        else m_wait++;
      end
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick("rst");
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    memread_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1; br_taken_EX = 1; dmem_req = 1;
    tick("rst_hold0");
    tick("rst_hold1");
    clear_inputs();
    reset = 0;
    tick("idle");

    // Load-use on rs1: one bubble.
    memread_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1;
    tick("lu_rs1");
    clear_inputs();
    tick("lu_after");
    check("lu_scnt_is_1", 32'(stall_cnt), 1);

    // No hazard when rd is x0 or the source is unused.
    memread_EX = 1; rd_EX = 0; rs1_ID = 0; use_rs1_ID = 1;
    tick("lu_x0");
    rd_EX = 5; rs1_ID = 5; use_rs1_ID = 0;
    tick("lu_unused");
    clear_inputs();
    memread_EX = 1; rd_EX = 7; rs2_ID = 7; use_rs2_ID = 1;
    tick("lu_rs2");

    // Redirect beats load-use.
    do_reset();
    memread_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1; br_taken_EX = 1;
    tick("br_lu");
    clear_inputs();
    tick("br_after");
    check("br_fcnt_is_1", 32'(flush_cnt), 1);

    // Freeze holds a taken branch for three cycles, redirect on the ready cycle.
    do_reset();
    dmem_req = 1; br_taken_EX = 1;
    for (int i = 0; i < 3; i++) tick("frz_br");
    dmem_ready = 1;
    tick("frz_ready");
    clear_inputs();
    tick("frz_after");
    check("frz_scnt_is_3", 32'(stall_cnt), 3);
    check("frz_fcnt_is_1", 32'(flush_cnt), 1);

    // Timeout: one entry cycle plus MAXW wait cycles, then HALT persists.
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < MAXW + 1; i++) tick("to_wait");
    clear_inputs();
    j_EX = 1;
    for (int i = 0; i < 3; i++) tick("to_halt");
    check("to_halted", 32'(halted), 1);
    do_reset();
    tick("to_cleared");
    check("to_cleared_flag", 32'(mem_timeout), 0);

    // Ready on the last allowed wait cycle returns to RUN.
    dmem_req = 1;
    for (int i = 0; i < MAXW; i++) tick("edge_wait");
    dmem_ready = 1;
    tick("edge_ready");
    clear_inputs();
    tick("edge_run");

    // Counter saturation.
    do_reset();
    memread_EX = 1; rd_EX = 3; rs2_ID = 3; use_rs2_ID = 1;
    for (int i = 0; i < 20; i++) tick("sat");
    clear_inputs();
    tick("sat_end");
    check("sat_scnt_15", 32'(stall_cnt), 15);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 39) == 0);
      memread_EX  = $urandom_range(0, 1) == 1;
      rd_EX       = 5'($urandom_range(0, 3));
      rs1_ID      = 5'($urandom_range(0, 3));
      rs2_ID      = 5'($urandom_range(0, 3));
      use_rs1_ID  = $urandom_range(0, 1) == 1;
      use_rs2_ID  = $urandom_range(0, 1) == 1;
      br_taken_EX = $urandom_range(0, 4) == 0;
      j_EX        = $urandom_range(0, 6) == 0;
      dmem_req    = $urandom_range(0, 2) == 0;
      dmem_ready  = $urandom_range(0, 9) < 4;
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
